// File: rtl/qspi_bus_arbiter.sv
// Two-master quad-SPI pin arbiter: whole-transaction grants, pin mux, CS-high gap between owners.
// Optional owner timeout is compiled in when QSPI_ARB_TIMEOUT_EN is defined.
module qspi_bus_arbiter #(
    parameter int CS_GAP  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       init_done,
    input  logic [1:0] req,
    input  logic [1:0] done,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       timeout,
    input  logic       rq0_cs_n,
    input  logic       rq0_sclk,
    input  logic [3:0] rq0_io_o,
    input  logic [3:0] rq0_io_oe,
    input  logic       rq1_cs_n,
    input  logic       rq1_sclk,
    input  logic [3:0] rq1_io_o,
    input  logic [3:0] rq1_io_oe,
    output logic [3:0] rq_io_i,
    output logic       flash_cs_n,
    output logic       flash_sclk,
    output logic [3:0] flash_io_o,
    output logic [3:0] flash_io_oe,
    input  logic [3:0] flash_io_i
);
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    if (CS_GAP < 1 || TIMEOUT < 2) begin : g_bad_params
        $error("qspi_bus_arbiter: CS_GAP must be >= 1 and TIMEOUT >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN0,
        ST_OWN1,
        ST_GAP
    } state_t;

    state_t             state_reg, state_next;
    logic               last_owner_reg, last_owner_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [1:0]         gnt_reg;
    logic [1:0]         eligible;
    logic               owning;
    logic               own_idx;
    logic               release_now;
    logic               to_expired;

    // Requester 1 is invisible to arbitration until the init engine has finished.
    assign eligible    = {req[1] & init_done, req[0]};
    assign owning      = (state_reg == ST_OWN0) || (state_reg == ST_OWN1);
    assign own_idx     = (state_reg == ST_OWN1);
    assign release_now = done[own_idx] | ~req[own_idx];

    always_comb begin
        state_next      = state_reg;
        last_owner_next = last_owner_reg;
        gap_cnt_next    = '0;
        case (state_reg)
            ST_IDLE: begin
                if (eligible[0] && eligible[1])
                    state_next = last_owner_reg ? ST_OWN0 : ST_OWN1;
                else if (eligible[0])
                    state_next = ST_OWN0;
                else if (eligible[1])
                    state_next = ST_OWN1;
            end
            ST_OWN0, ST_OWN1: begin
                if (release_now || to_expired) begin
                    state_next      = ST_GAP;
                    last_owner_next = own_idx;
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == GAP_W'(CS_GAP - 1))
                    state_next = ST_IDLE;
                else
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg      <= ST_IDLE;
            last_owner_reg <= 1'b1;
            gap_cnt_reg    <= '0;
            gnt_reg        <= 2'b00;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
            gap_cnt_reg    <= gap_cnt_next;
            gnt_reg        <= {state_next == ST_OWN1, state_next == ST_OWN0};
        end
    end

`ifdef QSPI_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT);

    logic [TO_W-1:0] to_cnt_reg;
    logic            timeout_reg;
    logic            force_rel;

    // Ownership is only ever entered from IDLE, so clearing there restarts the count per grant.
    always_ff @(posedge ACLK) begin
        if (ARESET || state_reg == ST_IDLE)
            to_cnt_reg <= '0;
        else if (owning)
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end

    assign to_expired = owning && (to_cnt_reg == TO_W'(TIMEOUT - 1));
    assign force_rel  = to_expired && !release_now;

    always_ff @(posedge ACLK) begin
        if (ARESET)
            timeout_reg <= 1'b0;
        else
            timeout_reg <= force_rel;
    end

    assign timeout = timeout_reg;
`else
    assign to_expired = 1'b0;
    assign timeout    = 1'b0;
`endif

    assign gnt     = gnt_reg;
    assign busy    = (state_reg != ST_IDLE);
    assign rq_io_i = flash_io_i;

    // Pins follow the registered state; anything but ownership parks them.
    always_comb begin
        flash_cs_n  = 1'b1;
        flash_sclk  = 1'b0;
        flash_io_o  = 4'h0;
        flash_io_oe = 4'h0;
        if (state_reg == ST_OWN0) begin
            flash_cs_n  = rq0_cs_n;
            flash_sclk  = rq0_sclk;
            flash_io_o  = rq0_io_o;
            flash_io_oe = rq0_io_oe;
        end else if (state_reg == ST_OWN1) begin
            flash_cs_n  = rq1_cs_n;
            flash_sclk  = rq1_sclk;
            flash_io_o  = rq1_io_o;
            flash_io_oe = rq1_io_oe;
        end
    end
endmodule

// File: doc/qspi_bus_arbiter.md
# qspi_bus_arbiter

Arbitrates a single quad-SPI flash pin set between two masters: requester 0, the boot-time init engine that raises `flag_end_init`, and requester 1, a runtime flash reader on the AXI4-Lite side. Grants whole transactions, muxes the selected master's SCLK/CS/IO onto the flash pins and enforces a minimum CS-high gap between owners. Until initialisation completes only requester 0 is served; afterwards the two masters alternate round-robin.

## Interface
- `CS_GAP`, 4: cycles flash CS held high between consecutive grants (≥1).
- `TIMEOUT`, 1024: cycles an owner may hold the bus without `done` (≥2; used only with the timeout feature).
- `ACLK`  in  1  clock.
- `ARESET`  in  1  reset, synchronous, active-high.
- `init_done`  in  1  level from init engine (`flag_end_init`); while low, `req[1]` is masked.
- `req`  in  2  per-requester bus request, level, held until granted and finished.
- `done`  in  2  per-requester single-cycle end-of-transaction pulse.
- `gnt`  out  2  one-hot grant, registered.
- `busy`  out  1  high in any non-IDLE state.
- `timeout`  out  1  one-cycle pulse on forced release.
- `rq0_cs_n`, `rq0_sclk`  in  1 each  requester 0 pin drive.
- `rq0_io_o`, `rq0_io_oe`  in  4 each  requester 0 IO data / output enable.
- `rq1_cs_n`, `rq1_sclk`, `rq1_io_o`, `rq1_io_oe`  in  1/1/4/4  requester 1 equivalents.
- `rq_io_i`  out  4  flash IO input, broadcast to both requesters.
- `flash_cs_n`, `flash_sclk`  out  1 each  to flash.
- `flash_io_o`, `flash_io_oe`  out  4 each  to flash IO pads.
- `flash_io_i`  in  4  from flash IO pads.

## Operation
- States: IDLE, OWN0, OWN1, GAP. Registers: state, `last_owner`, gap counter, timeout counter.
- IDLE: eligible = `req[0]`, plus `req[1]` only if `init_done`. One eligible → grant it. Both eligible → grant the one ≠ `last_owner`. None → stay.
- OWNx: `gnt[x]=1`; flash pins = requester x pins, combinationally muxed by the registered state. Exit to GAP when `done[x]` or `req[x]` low; `last_owner` ← x. Requests from the other master are held off.
- GAP: parked pins for exactly `CS_GAP` cycles, then IDLE.
- Parked pins (IDLE, GAP, reset): `flash_cs_n=1`, `flash_sclk=0`, `flash_io_o=0`, `flash_io_oe=0`.
- `rq_io_i = flash_io_i` always (no gating, no register).
- `done` from a non-owner is ignored. `init_done` falling while OWN1 does not revoke; only new grants are masked.
- Reset: state IDLE, `gnt=00`, `busy=0`, `timeout=0`, pins parked, `last_owner=1` (requester 0 wins first tie), counters 0.

## Timing
- Grant latency: request seen high at edge N in IDLE → `gnt` high after edge N; owner pins reach flash in that same cycle.
- Release: `done[x]` sampled at edge M → after M state GAP, `gnt=00`, pins parked; IDLE after edge M+`CS_GAP`; earliest next grant after edge M+`CS_GAP`+1.
- Minimum CS-high between owners: `CS_GAP`+1 cycles.
- `done[x]` and `req[x]` low in the same cycle: a single release.
- Simultaneous `req` of both in IDLE: one grant only; never two `gnt` bits high.
- Mid-transaction `ARESET`: takes effect at the next edge, pins parked immediately after, no GAP.

## Configuration
- `QSPI_ARB_TIMEOUT_EN` defined: counter clears on entering OWNx and increments each OWNx cycle; at `TIMEOUT`-1 without release, next edge forces GAP, `timeout` pulses one cycle, `last_owner` ← x. Requester must drop `req` before re-arbitration sees it again; it is otherwise treated as a new request.
- Not defined: no counter; `timeout` tied 0; an owner holds the bus indefinitely.

## Test plan
- Reset then `req=01`, `init_done=0` → `gnt=01` next cycle; pins follow rq0; `done[0]` → 4 parked cycles, then IDLE.
- `init_done=0`, `req=10` for 50 cycles → `gnt` stays 00, `busy=0`; raise `init_done` → `gnt=10` next cycle.
- `init_done=1`, `req=11` held, each owner pulses `done` after 8 cycles → grants alternate 01,10,01,10, `CS_GAP`+1 CS-high cycles between each.
- OWN0 with `done[1]` pulsed → no effect; `req[0]` dropped → GAP entered.
- `QSPI_ARB_TIMEOUT_EN`, `TIMEOUT=16`, owner never sends `done` → release after 16 owner cycles, `timeout` one-cycle pulse, other requester granted after gap.
- `ARESET` pulsed mid-OWN1 → next cycle `gnt=00`, `flash_cs_n=1`, `io_oe=0`; with `req=11`, requester 0 granted first.
